// File: rtl/task_ser_pkg.sv
// rtl/task_ser_pkg.sv - shared types and constants for the task output serializer
package task_ser_pkg;

  localparam int BYTE_W     = 8;
  localparam int DEF_TASK_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CHK  = 2'd2
  } ser_state_t;

  typedef struct packed {
    logic                  last;
    logic [DEF_TASK_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/task_ser_fifo.sv
// rtl/task_ser_fifo.sv - word FIFO with count-based full/empty
// A push while full is ignored even if a pop happens on the same edge.
module task_ser_fifo
  import task_ser_pkg::*;
#(
  parameter int  DEPTH   = 16,
  parameter type entry_t = fifo_entry_t
) (
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_push,
  input  entry_t i_wdata,
  input  logic   i_pop,
  output entry_t o_rdata,
  output logic   o_full,
  output logic   o_empty
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign o_full  = (count_q == (AW+1)'(DEPTH));
  assign o_empty = (count_q == '0);
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;
  assign o_rdata = mem_q[rd_ptr_q];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_wdata;
  end

endmodule

// File: rtl/task_output_serializer.sv
// rtl/task_output_serializer.sv - splits buffered task words into MSB-first bytes for UART TX
// TASK_SER_CHECKSUM_EN appends an XOR checksum byte after each frame.
module task_output_serializer
  import task_ser_pkg::*;
#(
  parameter int TASK_OUTPUT_WIDTH = 32,
  parameter int FIFO_DEPTH        = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_valid,
  input  logic                         i_last,
  input  logic [TASK_OUTPUT_WIDTH-1:0] i_data,
  output logic                         o_tx_valid,
  input  logic                         i_tx_ready,
  output logic [BYTE_W-1:0]            o_tx_data,
  output logic                         o_tx_last,
  output logic                         o_overflow,
  output logic                         o_busy
);

  localparam int BPW = TASK_OUTPUT_WIDTH / BYTE_W;
  localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;
`ifdef TASK_SER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef struct packed {
    logic                         last;
    logic [TASK_OUTPUT_WIDTH-1:0] data;
  } entry_t;

  entry_t                       fifo_wdata;
  entry_t                       fifo_rdata;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic                         fifo_pop;

  ser_state_t                   state_q;
  logic [TASK_OUTPUT_WIDTH-1:0] word_q;
  logic                         last_q;
  logic [IW-1:0]                idx_q;
  logic                         tx_valid_q;
  logic [BYTE_W-1:0]            tx_data_q;
  logic                         tx_last_q;
  logic                         overflow_q;
  logic                         xfer;
  logic                         final_byte;
  logic                         to_chk;
  logic                         word_done;

  function automatic logic [BYTE_W-1:0] byte_at(input logic [TASK_OUTPUT_WIDTH-1:0] w,
                                                input logic [IW-1:0] i);
    logic [BPW-1:0][BYTE_W-1:0] b;
    b = w;
    return b[IW'(BPW-1) - i];
  endfunction

  // Without the checksum the frame ends on the last word's final byte.
  function automatic logic frame_end(input logic last, input logic [IW-1:0] i);
    return !CHK_EN && last && (i == IW'(BPW-1));
  endfunction

  assign fifo_wdata = '{last: i_last, data: i_data};

  task_ser_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_valid),
    .i_wdata (fifo_wdata),
    .i_pop   (fifo_pop),
    .o_rdata (fifo_rdata),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

`ifdef TASK_SER_CHECKSUM_EN
  logic [BYTE_W-1:0] chk_q;
  assign to_chk = last_q;
`else
  assign to_chk = 1'b0;
`endif

  assign xfer       = tx_valid_q && i_tx_ready;
  assign final_byte = (idx_q == IW'(BPW-1));
  assign word_done  = xfer && ((state_q == SEND && final_byte && !to_chk) || state_q == CHK);
  assign fifo_pop   = (state_q == IDLE || word_done) && !fifo_empty;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= IDLE;
      word_q     <= '0;
      last_q     <= 1'b0;
      idx_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_last_q  <= 1'b0;
    end else if (state_q == IDLE) begin
      if (fifo_pop) begin
        word_q  <= fifo_rdata.data;
        last_q  <= fifo_rdata.last;
        idx_q   <= '0;
        state_q <= SEND;
      end
    end else if (!tx_valid_q) begin
      tx_valid_q <= 1'b1;
      tx_data_q  <= byte_at(word_q, idx_q);
      tx_last_q  <= frame_end(last_q, idx_q);
    end else if (xfer) begin
      if (state_q == SEND && !final_byte) begin
        idx_q     <= idx_q + IW'(1);
        tx_data_q <= byte_at(word_q, idx_q + IW'(1));
        tx_last_q <= frame_end(last_q, idx_q + IW'(1));
      end
`ifdef TASK_SER_CHECKSUM_EN
      else if (state_q == SEND && to_chk) begin
        state_q   <= CHK;
        tx_data_q <= chk_q ^ tx_data_q;
        tx_last_q <= 1'b1;
      end
`endif
      else if (fifo_pop) begin
        // Next word goes straight to the output register: no bubble between words.
        word_q    <= fifo_rdata.data;
        last_q    <= fifo_rdata.last;
        idx_q     <= '0;
        state_q   <= SEND;
        tx_data_q <= byte_at(fifo_rdata.data, '0);
        tx_last_q <= frame_end(fifo_rdata.last, '0);
      end else begin
        state_q    <= IDLE;
        tx_valid_q <= 1'b0;
        tx_data_q  <= '0;
        tx_last_q  <= 1'b0;
      end
    end
  end

`ifdef TASK_SER_CHECKSUM_EN
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)    chk_q <= '0;
    else if (xfer) chk_q <= (state_q == CHK) ? '0 : (chk_q ^ tx_data_q);
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                     overflow_q <= 1'b0;
    else if (i_valid && fifo_full)  overflow_q <= 1'b1;
  end

  assign o_tx_valid = tx_valid_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_last  = tx_last_q;
  assign o_overflow = overflow_q;
  assign o_busy     = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_task_output_serializer.sv
// tb/tb_task_output_serializer.sv - scoreboard bench for task_output_serializer
module tb_task_output_serializer;

  localparam int BPW = 4;
`ifdef TASK_SER_CHECKSUM_EN
  localparam int CHK_BYTES = 1;
`else
  localparam int CHK_BYTES = 0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_last = 1'b0;
  logic [31:0] i_data = '0;
  logic        i_tx_ready = 1'b0;
  logic        o_tx_valid;
  logic [7:0]  o_tx_data;
  logic        o_tx_last;
  logic        o_overflow;
  logic        o_busy;

  int          checks = 0;
  int          errors = 0;
  int          xfer_cnt = 0;
  logic [8:0]  sb[$];
  logic [7:0]  m_chk = '0;

  task_output_serializer #(
    .TASK_OUTPUT_WIDTH (32),
    .FIFO_DEPTH        (16)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .i_last     (i_last),
    .i_data     (i_data),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (i_tx_ready),
    .o_tx_data  (o_tx_data),
    .o_tx_last  (o_tx_last),
    .o_overflow (o_overflow),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_word(input logic [31:0] d, input logic l, input bit accept);
    i_valid = 1'b1;
    i_last  = l;
    i_data  = d;
    if (accept) begin
      for (int b = 0; b < BPW; b++) begin
        logic [7:0] by;
        by = d[(BPW-1-b)*8 +: 8];
        m_chk ^= by;
        sb.push_back({(CHK_BYTES == 0) && l && (b == BPW-1), by});
      end
      if (l && CHK_BYTES != 0) begin
        sb.push_back({1'b1, m_chk});
        m_chk = '0;
      end
    end
    @(posedge i_clk); #1;
  endtask

  task automatic do_reset(input string tag);
    i_rst = 1'b0;
    i_valid = 1'b0;
    i_last = 1'b0;
    i_data = '0;
    i_tx_ready = 1'b0;
    sb.delete();
    m_chk = '0;
    #1;
    chk({tag, "_valid"}, o_tx_valid, 0);
    chk({tag, "_data_last"}, {o_tx_last, o_tx_data}, 0);
    chk({tag, "_overflow"}, o_overflow, 0);
    chk({tag, "_busy"}, o_busy, 0);
    @(posedge i_clk); #1;
    i_rst = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (o_tx_valid !== 1'b1 && n < 20) begin
      @(posedge i_clk); #1;
      n++;
    end
    chk({tag, "_valid_seen"}, o_tx_valid, 1);
  endtask

  task automatic expect_run(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_run"}, o_tx_valid, 1);
      @(posedge i_clk); #1;
    end
    chk({tag, "_run_end"}, o_tx_valid, 0);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || o_busy) && n < 400) begin
      @(posedge i_clk); #1;
      n++;
    end
    chk({tag, "_drained"}, sb.size(), 0);
    chk({tag, "_idle"}, {o_busy, o_tx_valid}, 0);
  endtask

  // Byte monitor: every transfer is popped against the scoreboard; stalls must hold.
  initial begin
    logic        stall_pend;
    logic [8:0]  held;
    logic [31:0] exp;
    stall_pend = 1'b0;
    held = '0;
    forever begin
      @(negedge i_clk);
      if (!i_rst) begin
        stall_pend = 1'b0;
      end else begin
        if (stall_pend) begin
          chk("stall_valid", o_tx_valid, 1);
          chk("stall_hold", {o_tx_last, o_tx_data}, held);
        end
        if (o_tx_valid && i_tx_ready) begin
          if (sb.size() > 0) exp = {23'd0, sb.pop_front()};
          else               exp = 32'hFFFF_FFFF;
          chk("byte", {o_tx_last, o_tx_data}, exp);
          xfer_cnt++;
        end
        stall_pend = o_tx_valid && !i_tx_ready;
        held = {o_tx_last, o_tx_data};
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int base;
    #2;

    do_reset("rst0");
    i_tx_ready = 1'b1;
    drive_word(32'hA1B2C3D4, 1'b1, 1'b1);
    i_valid = 1'b0;
    chk("t1_lat_n", o_tx_valid, 0);
    @(posedge i_clk); #1;
    chk("t1_lat_n1", o_tx_valid, 0);
    @(posedge i_clk); #1;
    chk("t1_lat_n2", o_tx_valid, 1);
    chk("t1_first_byte", o_tx_data, 8'hA1);
    expect_run("t1", BPW + CHK_BYTES);
    wait_drain("t1");

    do_reset("rst2");
    drive_word(32'hA1B2C3D4, 1'b1, 1'b1);
    i_valid = 1'b0;
    wait_valid("t2");
    i_tx_ready = 1'b1; @(posedge i_clk); #1;
    i_tx_ready = 1'b0; @(posedge i_clk); #1;
    i_tx_ready = 1'b0; @(posedge i_clk); #1;
    i_tx_ready = 1'b1; @(posedge i_clk); #1;
    i_tx_ready = 1'b0; @(posedge i_clk); #1;
    i_tx_ready = 1'b1; @(posedge i_clk); #1;
    i_tx_ready = 1'b1; @(posedge i_clk); #1;
    wait_drain("t2");

    do_reset("rst4");
    i_tx_ready = 1'b1;
    drive_word(32'h01020304, 1'b1, 1'b1);
    i_valid = 1'b0;
    wait_drain("t4a");
    drive_word(32'h01020304, 1'b1, 1'b1);
    i_valid = 1'b0;
    wait_drain("t4b");

    do_reset("rst5");
    i_tx_ready = 1'b1;
    drive_word(32'h11223344, 1'b0, 1'b1);
    drive_word(32'h55667788, 1'b1, 1'b1);
    i_valid = 1'b0;
    wait_valid("t5");
    expect_run("t5", 2*BPW + CHK_BYTES);
    wait_drain("t5");

    do_reset("rst3");
    drive_word(32'hF0F1F2F3, 1'b0, 1'b1);
    i_valid = 1'b0;
    wait_valid("t3_prime");
    for (int k = 1; k <= 20; k++) begin
      drive_word(32'h1000_0000 + 32'(k), (k == 16), (k <= 16));
      chk($sformatf("t3_ovf_w%0d", k), o_overflow, (k >= 17));
    end
    i_valid = 1'b0;
    base = xfer_cnt;
    i_tx_ready = 1'b1;
    wait_drain("t3");
    chk("t3_byte_count", xfer_cnt - base, 17*BPW + CHK_BYTES);
    chk("t3_ovf_sticky", o_overflow, 1);

    i_tx_ready = 1'b0;
    drive_word(32'hCAFEF00D, 1'b1, 1'b1);
    i_valid = 1'b0;
    wait_valid("t6");
    i_tx_ready = 1'b1; @(posedge i_clk); #1;
    i_tx_ready = 1'b0;
    chk("t6_second_byte", {o_tx_valid, o_tx_data}, {1'b1, 8'hFE});
    chk("t6_busy_before", {o_busy, o_overflow}, 2'b11);
    do_reset("t6_mid");
    repeat (3) begin
      @(posedge i_clk); #1;
    end
    chk("t6_no_resume", o_tx_valid, 0);
    i_tx_ready = 1'b1;
    drive_word(32'h5A6B7C8D, 1'b1, 1'b1);
    i_valid = 1'b0;
    wait_valid("t6_after");
    expect_run("t6_after", BPW + CHK_BYTES);
    wait_drain("t6_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
